// File: rtl/thresh_pkg.sv
// Shared types and constants for the threshold-table loader.
package thresh_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   // Largest table entry representable in CNT_WIDTH+1 bits.
   function automatic int unsigned SAT_MAX(input int unsigned cnt_width);
      return (32'd1 << (cnt_width + 1)) - 32'd1;
   endfunction

endpackage

// File: rtl/thresh_table_loader_if.sv
// Comparator RAM write port driven by the threshold-table loader.
interface thresh_table_loader_if #(
   parameter int CNT_WIDTH = 10
);
   logic [CNT_WIDTH-1:0] o_BRAM_Addr;
   logic [CNT_WIDTH:0]   o_BRAM_Din;
   logic                 o_BRAM_En;
   logic                 o_BRAM_WrEn;

   modport master (output o_BRAM_Addr, output o_BRAM_Din, output o_BRAM_En, output o_BRAM_WrEn);
   modport slave  (input  o_BRAM_Addr, input  o_BRAM_Din, input  o_BRAM_En, input  o_BRAM_WrEn);
endinterface

// File: rtl/thresh_accum.sv
// Saturating fixed-point accumulator: value = floor(acc), sticky at SAT_MAX once
// the integer part no longer fits in CNT_WIDTH+1 bits.
module thresh_accum
   import thresh_pkg::*;
#(
   parameter int CNT_WIDTH = 10,
   parameter int FRAC_BITS = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_clr,
   input  logic                          i_step,
   input  logic [CNT_WIDTH+FRAC_BITS-1:0] i_inc,
   output logic [CNT_WIDTH:0]            o_value,
   output logic                          o_sat
);

   localparam int AW = CNT_WIDTH + FRAC_BITS + 2;
   localparam logic [CNT_WIDTH:0] SAT_VAL = (CNT_WIDTH+1)'(SAT_MAX(CNT_WIDTH));

   logic [AW-1:0] r_acc;
   logic [AW-1:0] w_sum;

   // Guard bit at the top: acc < 2^(AW-1) and inc < 2^(AW-2), so the sum never wraps.
   assign w_sum = r_acc + AW'(i_inc);

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_acc <= '0;
      end else if (i_step && !r_acc[AW-1]) begin
         r_acc <= w_sum[AW-1] ? '1 : w_sum;
      end
   end

   assign o_sat   = r_acc[AW-1];
   assign o_value = r_acc[AW-1] ? SAT_VAL : r_acc[FRAC_BITS +: CNT_WIDTH+1];

endmodule

// File: rtl/thresh_table_loader.sv
// Fills the popcount-threshold table entry[c] = min(floor(c*M), SAT_MAX), c = 0..VECTOR_WIDTH.
// Optional running checksum of written entries under THRESH_TABLE_LOADER_CSUM_EN.
//
// state | meaning
// IDLE  | waiting for i_Start; outputs held
// LOAD  | one RAM write per cycle, address 0..VECTOR_WIDTH
// DONE  | single-cycle o_Done pulse, then back to IDLE
module thresh_table_loader
   import thresh_pkg::*;
#(
   parameter int VECTOR_WIDTH = 920,
   parameter int CNT_WIDTH    = $clog2(VECTOR_WIDTH),
   parameter int FRAC_BITS    = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_Start,
   input  logic [CNT_WIDTH+FRAC_BITS-1:0] i_Ratio,
   output logic                           o_Busy,
   output logic                           o_Done,
`ifdef THRESH_TABLE_LOADER_CSUM_EN
   output logic [CNT_WIDTH+10:0]          o_Checksum,
`endif
   thresh_table_loader_if.master          bram
);

   localparam logic [CNT_WIDTH-1:0] LAST_ADDR = CNT_WIDTH'(VECTOR_WIDTH);

   state_t                         r_state;
   logic                           r_busy;
   logic                           r_done;
   logic                           r_en;
   logic [CNT_WIDTH-1:0]           r_addr;
   logic [CNT_WIDTH+FRAC_BITS-1:0] r_ratio;

   logic                           w_clr;
   logic                           w_step;
   logic                           w_sat;
   logic [CNT_WIDTH:0]             w_value;

   assign w_clr  = (r_state == IDLE) && i_Start;
   // No step after the final write so Din holds the last entry while idle.
   assign w_step = (r_state == LOAD) && (r_addr != LAST_ADDR) && !w_sat;

   thresh_accum #(
      .CNT_WIDTH (CNT_WIDTH),
      .FRAC_BITS (FRAC_BITS)
   ) u_accum (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_clr),
      .i_step  (w_step),
      .i_inc   (r_ratio),
      .o_value (w_value),
      .o_sat   (w_sat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_en    <= 1'b0;
         r_addr  <= '0;
         r_ratio <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (i_Start) begin
                  r_ratio <= i_Ratio;
                  r_addr  <= '0;
                  r_busy  <= 1'b1;
                  r_en    <= 1'b1;
                  r_state <= LOAD;
               end
            end
            LOAD: begin
               if (r_addr == LAST_ADDR) begin
                  r_en    <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_addr <= r_addr + 1'b1;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_en    <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_Busy           = r_busy;
   assign o_Done           = r_done;
   assign bram.o_BRAM_Addr = r_addr;
   assign bram.o_BRAM_Din  = w_value;
   assign bram.o_BRAM_En   = r_en;
   assign bram.o_BRAM_WrEn = r_en;

`ifdef THRESH_TABLE_LOADER_CSUM_EN
   logic [CNT_WIDTH+10:0] r_csum;

   always_ff @(posedge clk) begin
      if (rst || w_clr) begin
         r_csum <= '0;
      end else if (r_en) begin
         r_csum <= r_csum + (CNT_WIDTH+11)'(w_value);
      end
   end

   assign o_Checksum = r_csum;
`endif

endmodule

// File: doc/thresh_table_loader.md
THRESH_TABLE_LOADER -- requirements
Module: thresh_table_loader

Interface
REQ-001 SHALL have parameter VECTOR_WIDTH, default 920: fingerprint bit length; the table holds VECTOR_WIDTH+1 entries.
REQ-002 SHALL have parameter CNT_WIDTH, default $clog2(VECTOR_WIDTH): popcount width.
REQ-003 SHALL have parameter FRAC_BITS, default 8: fractional bits of i_Ratio.
REQ-004 SHALL have port clk  input  1: the single clock.
REQ-005 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port i_Start  input  1: single-cycle load request.
REQ-007 SHALL have port i_Ratio  input  CNT_WIDTH+FRAC_BITS: unsigned fixed-point M=(1+t)/t, where t is the Tanimoto threshold.
REQ-008 SHALL have port o_Busy  output  1: a load is in progress.
REQ-009 SHALL have port o_Done  output  1: one-cycle pulse on load completion.
REQ-010 SHALL have port o_BRAM_Addr  output  CNT_WIDTH: table write address, which is the CntC value.
REQ-011 SHALL have port o_BRAM_Din  output  CNT_WIDTH+1: table entry.
REQ-012 SHALL have port o_BRAM_En  output  1: RAM enable.
REQ-013 SHALL have port o_BRAM_WrEn  output  1: RAM write enable.

Function
REQ-014 SHALL implement the FSM states IDLE, LOAD and DONE.
REQ-015 SHALL latch i_Ratio, clear address counter and accumulator, and enter LOAD on i_Start in IDLE.
REQ-016 SHALL ignore i_Start in LOAD and DONE; the latched ratio stays unchanged.
REQ-017 SHALL, in LOAD, write one entry per cycle with o_BRAM_En=o_BRAM_WrEn=1, starting at address 0 in the first LOAD cycle.
REQ-018 SHALL compute entry[c] = floor(c*M) using an accumulator, acc += ratio per step, with no multiplier.
REQ-019 SHALL size the accumulator to CNT_WIDTH+1+FRAC_BITS bits plus one guard bit.
REQ-020 SHALL set o_BRAM_Din to acc >> FRAC_BITS, saturated to 2^(CNT_WIDTH+1)-1 when it overflows.
REQ-021 SHALL hold saturation for all higher addresses once it is reached; the accumulator is saturated as well and does not wrap.
REQ-022 SHALL end LOAD after address VECTOR_WIDTH, giving exactly VECTOR_WIDTH+1 write cycles.
REQ-023 SHALL move LOAD to DONE; DONE asserts o_Done for one cycle and returns to IDLE.
REQ-024 SHALL hold o_Busy=1 in LOAD and DONE, and 0 in IDLE.
REQ-025 SHALL give a latency from the i_Start cycle to the o_Done cycle of VECTOR_WIDTH+2 cycles.
REQ-026 SHALL keep o_BRAM_En and o_BRAM_WrEn at 0 outside LOAD, with address and data held at their last value.
REQ-027 SHALL accept i_Ratio=0: all entries are 0.
REQ-028 SHALL accept a back-to-back i_Start in the cycle after o_Done, treated as in IDLE.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, enter IDLE regardless of state.
REQ-030 SHALL drive o_Busy, o_Done, o_BRAM_En, o_BRAM_WrEn, o_BRAM_Addr and o_BRAM_Din to 0, and clear the accumulator and latched ratio.
REQ-031 SHALL abort a load when reset arrives mid-LOAD: no further writes, no o_Done, and the table is left partially written.
REQ-032 SHALL give rst priority over a coincident i_Start.

Configuration
REQ-033 SHALL support macro THRESH_TABLE_LOADER_CSUM_EN; when defined, add output o_Checksum of width CNT_WIDTH+11.
REQ-034 SHALL, with that macro, compute o_Checksum as the sum of all written o_BRAM_Din, cleared on start and reset, and valid when o_Done=1.
REQ-035 SHALL, without that macro, omit the port and its logic entirely.

Structure
REQ-036 SHALL place the FSM state typedef (IDLE/LOAD/DONE) and a SAT_MAX constant function of CNT_WIDTH in the shared package thresh_pkg.
REQ-037 SHALL use one natural sub-module, thresh_accum: a saturating fixed-point accumulator with clear, step and value/saturated outputs.
REQ-038 SHALL connect its outputs directly to the comparator RAM write port through the wrapper.

Verification
Common setup: VECTOR_WIDTH=920, CNT_WIDTH=10, FRAC_BITS=8.
REQ-039 SHALL cover: i_Ratio=768 (M=3.0, t=0.5) -> entry[0]=0, entry[100]=300, entry[682]=2046, entry[683..920]=2047; o_Done at cycle 922.
REQ-040 SHALL cover: i_Ratio=640 (M=2.5) -> entry[1]=2, entry[2]=5, entry[3]=7, entry[920]=2047.
REQ-041 SHALL cover: i_Ratio=0 -> 921 writes, all Din=0, one o_Done pulse.
REQ-042 SHALL cover: i_Start re-pulsed with i_Ratio=256 at LOAD cycle 50 -> ignored, entries continue as M=3.0, single o_Done.
REQ-043 SHALL cover: rst at LOAD cycle 300 -> the next cycle shows all outputs 0, no o_Done; a fresh i_Start then rewrites from address 0.
REQ-044 SHALL cover, with THRESH_TABLE_LOADER_CSUM_EN and i_Ratio=256 (M=1.0): o_Checksum=423660 at o_Done.
